// File: rtl/picorv32_pcpi_issue.sv
// PCPI initiator: accepts (insn, rs1, rs2) commands, drives one PCPI transaction at a time,
// and returns the coprocessor result or a timeout status on a valid/ready response port.
module picorv32_pcpi_issue #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MIN_GAP        = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GCNT_LAST = GW'(MIN_GAP - 1);
  localparam logic [1:0] STAT_OK_WR   = 2'b00;
  localparam logic [1:0] STAT_OK_NOWR = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] tcnt_r, tcnt_s;
  logic [GW-1:0] gcnt_r, gcnt_s;
  logic          claimed_r, claimed_s;
  logic [31:0]   insn_r, insn_s;
  logic [31:0]   rs1_r, rs1_s;
  logic [31:0]   rs2_r, rs2_s;
  logic [31:0]   rsp_data_r, rsp_data_s;
  logic [1:0]    rsp_status_r, rsp_status_s;
  logic          cmd_ready_r;
  logic          pcpi_valid_r;
  logic          rsp_valid_r;
  logic          busy_r;

  // Next-state, counters, operand latch and response capture
  always_comb begin
    state_s      = state_r;
    tcnt_s       = tcnt_r;
    gcnt_s       = gcnt_r;
    claimed_s    = claimed_r;
    insn_s       = insn_r;
    rs1_s        = rs1_r;
    rs2_s        = rs2_r;
    rsp_data_s   = rsp_data_r;
    rsp_status_s = rsp_status_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_s   = ST_ISSUE;
          tcnt_s    = {TW{1'b0}};
          claimed_s = 1'b0;
          insn_s    = cmd_insn;
          rs1_s     = cmd_rs1;
          rs2_s     = cmd_rs2;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The request cycle itself is not counted: responders answer one cycle late,
        // so the abort fires after TIMEOUT_CYCLES further silent cycles.
        if (pcpi_ready) begin
          state_s      = ST_RESP;
          rsp_data_s   = pcpi_wr ? pcpi_rd : 32'd0;
          rsp_status_s = pcpi_wr ? STAT_OK_WR : STAT_OK_NOWR;
        end else if (claimed_r || pcpi_wait) begin
          claimed_s = 1'b1;
        end else if (tcnt_r == TCNT_LAST) begin
          state_s      = ST_RESP;
          rsp_data_s   = 32'd0;
          rsp_status_s = STAT_TIMEOUT;
        end else begin
          tcnt_s = tcnt_r + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_GAP;
          gcnt_s  = {GW{1'b0}};
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_GAP: begin
        if (gcnt_r == GCNT_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gcnt_s = gcnt_r + GW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; handshake flags are decoded from the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      tcnt_r       <= {TW{1'b0}};
      gcnt_r       <= {GW{1'b0}};
      claimed_r    <= 1'b0;
      insn_r       <= 32'd0;
      rs1_r        <= 32'd0;
      rs2_r        <= 32'd0;
      rsp_data_r   <= 32'd0;
      rsp_status_r <= 2'b00;
      cmd_ready_r  <= 1'b0;
      pcpi_valid_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      tcnt_r       <= tcnt_s;
      gcnt_r       <= gcnt_s;
      claimed_r    <= claimed_s;
      insn_r       <= insn_s;
      rs1_r        <= rs1_s;
      rs2_r        <= rs2_s;
      rsp_data_r   <= rsp_data_s;
      rsp_status_r <= rsp_status_s;
      cmd_ready_r  <= (state_s == ST_IDLE);
      pcpi_valid_r <= (state_s == ST_ISSUE);
      rsp_valid_r  <= (state_s == ST_RESP);
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign pcpi_valid = pcpi_valid_r;
  assign pcpi_insn  = insn_r;
  assign pcpi_rs1   = rs1_r;
  assign pcpi_rs2   = rs2_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_picorv32_pcpi_issue.sv
// Directed bench for picorv32_pcpi_issue with a behavioural divider/slow responder and a
// scoreboard of expected responses.
module tb_picorv32_pcpi_issue;

  localparam int T = 16;
  localparam int G = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        busy;

  logic        m_wait, m_ready, m_wr, rbusy, rdone;
  logic [31:0] m_rd;
  int          rcnt;
  int          rmode = 0;
  logic        stray_ready = 1'b0, stray_wait = 1'b0;
  logic [31:0] stray_rd = 32'd0;

  assign pcpi_ready = m_ready | stray_ready;
  assign pcpi_wait  = m_wait | stray_wait;
  assign pcpi_wr    = stray_ready ? 1'b1 : m_wr;
  assign pcpi_rd    = stray_ready ? stray_rd : m_rd;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  picorv32_pcpi_issue #(.TIMEOUT_CYCLES(T), .MIN_GAP(G)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .busy(busy)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] div_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    case (f3)
      3'b100:  return (b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 32'd0) ? a : 32'($signed(a) % $signed(b));
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic claims(input logic [31:0] insn);
    if (rmode != 0) return 1'b1;
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && insn[14];
  endfunction

  // Responder: divider (mode 0) or slow no-write unit claiming everything (mode 1)
  always @(posedge clk) begin
    if (!resetn) begin
      m_wait <= 1'b0; m_ready <= 1'b0; m_wr <= 1'b0; m_rd <= 32'd0;
      rbusy <= 1'b0; rdone <= 1'b0; rcnt <= 0;
    end else begin
      m_ready <= 1'b0;
      if (!pcpi_valid) begin
        rbusy <= 1'b0; rdone <= 1'b0; m_wait <= 1'b0;
      end else if (rbusy) begin
        if (rcnt == 0) begin
          m_wait <= 1'b0; m_ready <= 1'b1; rbusy <= 1'b0; rdone <= 1'b1;
          if (rmode == 0) begin
            m_wr <= 1'b1;
            m_rd <= div_model(pcpi_insn[14:12], pcpi_rs1, pcpi_rs2);
          end else begin
            m_wr <= 1'b0;
            m_rd <= 32'hCAFE_0001;
          end
        end else begin
          rcnt <= rcnt - 1;
        end
      end else if (!rdone && claims(pcpi_insn)) begin
        rbusy <= 1'b1; m_wait <= 1'b1; rcnt <= (rmode == 0) ? 6 : 40;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [31:0] ed, input logic [1:0] es,
                          input logic hold, input string tag, output int pv_cyc);
    logic acc;
    exp_t e;
    acc = 1'b0;
    cmd_insn = insn; cmd_rs1 = a; cmd_rs2 = b; cmd_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (cmd_ready) begin
        acc = 1'b1;
        if (push) begin
          e.d = ed; e.s = es;
          sb.push_back(e);
        end
        step();
        break;
      end
      step();
    end
    if (!hold) cmd_valid = 1'b0;
    chk({tag, " accept"}, 32'(acc), 32'd1);
    chk({tag, " pv_rise"}, 32'(pcpi_valid), 32'd1);
    chk({tag, " pcpi_insn"}, pcpi_insn, insn);
    pv_cyc = cyc;
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int rise_cyc);
    logic seen;
    int   pv_bad;
    seen = 1'b0;
    pv_bad = 0;
    for (int n = 0; n < budget; n++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (!pcpi_valid || cmd_ready) pv_bad++;
      step();
    end
    chk({tag, " rsp_seen"}, 32'(seen), 32'd1);
    chk({tag, " pv_held"}, 32'(pv_bad), 32'd0);
    chk({tag, " pv_low_at_rsp"}, 32'(pcpi_valid), 32'd0);
    rise_cyc = cyc;
  endtask

  task automatic take_rsp(input string tag, output int hs_cyc);
    exp_t e;
    e = '0;
    chk({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, " data"}, rsp_data, e.d);
    chk({tag, " status"}, {30'd0, rsp_status}, {30'd0, e.s});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    hs_cyc = cyc;
    chk({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " gap_no_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pv, r, hs;
    logic pushed;
    exp_t e;
    resetn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_insn = 32'd0; cmd_rs1 = 32'd0; cmd_rs2 = 32'd0;
    step(); step(); step();
    chk("rst pcpi_valid", 32'(pcpi_valid), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst rsp_status", {30'd0, rsp_status}, 32'd0);
    chk("rst pcpi_insn", pcpi_insn, 32'd0);
    chk("rst pcpi_rs1", pcpi_rs1, 32'd0);
    resetn = 1'b1;
    step();
    chk("post_rst cmd_ready", 32'(cmd_ready), 32'd1);

    // Stray handshake pulses while idle
    stray_ready = 1'b1; stray_wait = 1'b1; stray_rd = 32'hDEAD_BEEF;
    step();
    stray_ready = 1'b0; stray_wait = 1'b0;
    step();
    chk("stray_idle busy", 32'(busy), 32'd0);
    chk("stray_idle rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_idle rsp_data", rsp_data, 32'd0);

    send_cmd(mk(3'b101), 32'd100, 32'd7, 1'b1, 32'd14, 2'b00, 1'b0, "divu", pv);
    wait_rsp("divu", 64, r);
    take_rsp("divu", hs);
    send_cmd(mk(3'b100), 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 2'b00, 1'b0, "div", pv);
    wait_rsp("div", 64, r);
    take_rsp("div", hs);
    send_cmd(mk(3'b110), 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, "rem", pv);
    wait_rsp("rem", 64, r);
    take_rsp("rem", hs);
    send_cmd(mk(3'b101), 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, "divu0", pv);
    wait_rsp("divu0", 64, r);
    take_rsp("divu0", hs);
    send_cmd(mk(3'b111), 32'd5, 32'd0, 1'b1, 32'd5, 2'b00, 1'b0, "remu0", pv);
    wait_rsp("remu0", 64, r);
    take_rsp("remu0", hs);

    // MUL is not claimed by the divider: timeout
    send_cmd(mk(3'b000), 32'd3, 32'd4, 1'b1, 32'd0, 2'b10, 1'b0, "mul_to", pv);
    wait_rsp("mul_to", 64, r);
    chk("mul_to latency", 32'(r - pv), 32'(T + 1));
    take_rsp("mul_to", hs);

    // Back-to-back with cmd_valid held and a stalled response
    send_cmd(mk(3'b101), 32'd100, 32'd7, 1'b1, 32'd14, 2'b00, 1'b1, "b2b1", pv);
    cmd_insn = mk(3'b101); cmd_rs1 = 32'd1000; cmd_rs2 = 32'd10;
    wait_rsp("b2b1", 64, r);
    for (int i = 0; i < 5; i++) begin
      chk("b2b hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b hold rsp_data", rsp_data, 32'd14);
      chk("b2b hold cmd_ready", 32'(cmd_ready), 32'd0);
      stray_ready = (i == 2);
      stray_rd = 32'hDEAD_BEEF;
      step();
    end
    stray_ready = 1'b0;
    take_rsp("b2b1", hs);
    pushed = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (pcpi_valid) break;
      if (cmd_ready && cmd_valid && !pushed) begin
        e.d = 32'd100; e.s = 2'b00;
        sb.push_back(e);
        pushed = 1'b1;
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("b2b2 gap_cycles", 32'(cyc - hs), 32'(G + 1));
    chk("b2b2 pcpi_rs1", pcpi_rs1, 32'd1000);
    wait_rsp("b2b2", 64, r);
    take_rsp("b2b2", hs);

    // Slow responder: claims, waits 40 cycles, finishes without write
    rmode = 1;
    send_cmd(32'h0000_000B, 32'd1, 32'd2, 1'b1, 32'd0, 2'b01, 1'b0, "slow", pv);
    wait_rsp("slow", 100, r);
    take_rsp("slow", hs);
    rmode = 0;

    // Reset in the middle of a divide
    send_cmd(mk(3'b101), 32'd100, 32'd7, 1'b0, 32'd0, 2'b00, 1'b0, "midrst", pv);
    step(); step(); step();
    chk("midrst busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("midrst pcpi_valid", 32'(pcpi_valid), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    step();
    send_cmd(mk(3'b101), 32'd81, 32'd9, 1'b1, 32'd9, 2'b00, 1'b0, "after_rst", pv);
    wait_rsp("after_rst", 64, r);
    take_rsp("after_rst", hs);
    chk("sb empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
